// File: rtl/fx_bus_pkg.sv
// Shared definitions for the fx register bus arbiter: bus widths, FSM state
// encoding and requester (owner) encoding.
package fx_bus_pkg;

   localparam int FX_ADDR_W = 16;
   localparam int FX_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } fx_state_t;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } fx_owner_t;

endpackage

// File: rtl/fx_rr2.sv
// Two-way round-robin pick: on contention the requester that was not granted
// last wins; a lone requester always wins.
module fx_rr2
   import fx_bus_pkg::*;
(
   input  logic      a_req,
   input  logic      b_req,
   input  fx_owner_t last_gnt,
   output logic      gnt_valid,
   output fx_owner_t gnt_id
);

   always_comb begin
      gnt_valid = a_req | b_req;
      gnt_id    = OWN_A;
      if (a_req && b_req) begin
         gnt_id = (last_gnt == OWN_A) ? OWN_B : OWN_A;
      end else if (b_req) begin
         gnt_id = OWN_B;
      end
   end

endmodule

// File: rtl/fx_bus_arb.sv
// Arbiter/sequencer for the shared fx register bus: grants requester A or B,
// issues one write or read strobe, waits out the read latency and acks.
module fx_bus_arb
   import fx_bus_pkg::*;
#(
   parameter int READ_LAT = 1
) (
   input  logic                 clk_sys,
   input  logic                 rst_n,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic [FX_ADDR_W-1:0] a_addr,
   input  logic [FX_DATA_W-1:0] a_wdata,
   output logic                 a_ack,
   output logic [FX_DATA_W-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic [FX_ADDR_W-1:0] b_addr,
   input  logic [FX_DATA_W-1:0] b_wdata,
   output logic                 b_ack,
   output logic [FX_DATA_W-1:0] b_rdata,
   output logic [FX_ADDR_W-1:0] fx_waddr,
   output logic                 fx_wr,
   output logic [FX_DATA_W-1:0] fx_data,
   output logic [FX_ADDR_W-1:0] fx_raddr,
   output logic                 fx_rd,
   input  logic [FX_DATA_W-1:0] fx_q,
   output logic                 busy
);

   localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

   fx_state_t            state_q, state_nx;
   fx_owner_t            own_q, own_nx;
   fx_owner_t            last_gnt_q, last_gnt_nx;
   logic                 we_q, we_nx;
   logic [FX_ADDR_W-1:0] addr_q, addr_nx;
   logic [FX_DATA_W-1:0] wdata_q, wdata_nx;
   logic [1:0]           cnt_q, cnt_nx;
   logic [FX_DATA_W-1:0] a_rdata_nx, b_rdata_nx;
   logic                 gnt_valid;
   fx_owner_t            gnt_id;

   fx_rr2 u_rr2 (
      .a_req     (a_req),
      .b_req     (b_req),
      .last_gnt  (last_gnt_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      state_nx    = state_q;
      own_nx      = own_q;
      last_gnt_nx = last_gnt_q;
      we_nx       = we_q;
      addr_nx     = addr_q;
      wdata_nx    = wdata_q;
      cnt_nx      = cnt_q;
      a_rdata_nx  = a_rdata;
      b_rdata_nx  = b_rdata;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               own_nx   = gnt_id;
               we_nx    = (gnt_id == OWN_A) ? a_we    : b_we;
               addr_nx  = (gnt_id == OWN_A) ? a_addr  : b_addr;
               wdata_nx = (gnt_id == OWN_A) ? a_wdata : b_wdata;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_nx = ACK;
            end else begin
               state_nx = WAIT;
               cnt_nx   = CNT_INIT;
            end
         end
         WAIT: begin
            if (cnt_q != 2'd0) begin
               cnt_nx = cnt_q - 2'd1;
            end else begin
               if (own_q == OWN_A) a_rdata_nx = fx_q;
               else                b_rdata_nx = fx_q;
               state_nx = ACK;
            end
         end
         default: begin
            last_gnt_nx = own_q;
            state_nx    = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next-state view so each strobe and ack
   // lines up exactly with the state it belongs to.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         own_q      <= OWN_A;
         last_gnt_q <= OWN_B;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         a_ack      <= 1'b0;
         a_rdata    <= '0;
         b_ack      <= 1'b0;
         b_rdata    <= '0;
         fx_waddr   <= '0;
         fx_wr      <= 1'b0;
         fx_data    <= '0;
         fx_raddr   <= '0;
         fx_rd      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_nx;
         own_q      <= own_nx;
         last_gnt_q <= last_gnt_nx;
         we_q       <= we_nx;
         addr_q     <= addr_nx;
         wdata_q    <= wdata_nx;
         cnt_q      <= cnt_nx;
         a_rdata    <= a_rdata_nx;
         b_rdata    <= b_rdata_nx;
         a_ack      <= (state_nx == ACK) && (own_nx == OWN_A);
         b_ack      <= (state_nx == ACK) && (own_nx == OWN_B);
         fx_wr      <= (state_nx == ISSUE) && we_nx;
         fx_rd      <= (state_nx == ISSUE) && !we_nx;
         fx_waddr   <= ((state_nx == ISSUE) && we_nx) ? addr_nx  : '0;
         fx_data    <= ((state_nx == ISSUE) && we_nx) ? wdata_nx : '0;
         fx_raddr   <= (((state_nx == ISSUE) || (state_nx == WAIT)) && !we_nx) ? addr_nx : '0;
         busy       <= (state_nx != IDLE);
      end
   end

endmodule
